// File: rtl/aead_loader_pkg.sv
// aead_pkg: shared constants and FSM state type for the AEAD byte loader.
// No ports; imported by aead_loader.
package aead_pkg;
    localparam logic [7:0] CMD_ENC = 8'h01;
    localparam logic [7:0] CMD_DEC = 8'h02;
    localparam int NT_W = 128;
    typedef enum logic [2:0] {IDLE, KEY, NONCE, AD, TEXT, TAG, LAUNCH, WAIT} state_t;
endpackage

// File: rtl/aead_loader_if.sv
// aead_loader_if: byte-stream valid/ready link into the loader.
// in_data/in_valid driven by the master, in_ready driven by the slave (loader).
interface aead_loader_if;
    logic [7:0] in_data;
    logic in_valid;
    logic in_ready;
    modport master(output in_data, in_valid, input in_ready);
    modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/aead_loader.sv
// aead_loader: assembles a framed byte stream into key/nonce/AD/text/tag fields,
// launches one encrypt or decrypt, then waits for the matching ready rising edge.
// Ports: clk, rst (sync, active-high); stream (byte input, slave side);
// key/nonce/associated/text/tag_in (held fields); en_start/dec_start (launch pulses);
// en_ready/dec_ready (completion levels); busy; done/err (one-cycle pulses).
module aead_loader
    import aead_pkg::*;
#(
    parameter int KEY_l  = 128,
    parameter int A_l    = 40,
    parameter int text_l = 40
) (
    input  logic              clk,
    input  logic              rst,
    aead_loader_if.slave      stream,
    output logic [KEY_l-1:0]  key,
    output logic [NT_W-1:0]   nonce,
    output logic [A_l-1:0]    associated,
    output logic [text_l-1:0] text,
    output logic [NT_W-1:0]   tag_in,
    output logic              en_start,
    output logic              dec_start,
    input  logic              en_ready,
    input  logic              dec_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int KB = KEY_l / 8;
    localparam int AB = A_l / 8;
    localparam int TB = text_l / 8;
    localparam int M1 = KB > 16 ? KB : 16;
    localparam int M2 = AB > TB ? AB : TB;
    localparam int CW = $clog2(M1 > M2 ? M1 : M2) + 1;
    state_t state, nxt;
    logic [CW-1:0] cnt, lim;
    logic is_dec, en_prev, dec_prev, acc, legal, last, fire;
    always_comb begin
        stream.in_ready = state != LAUNCH && state != WAIT;
        busy = state != IDLE;
        // a launch pulse is dropped if reset lands in the LAUNCH cycle
        en_start = state == LAUNCH && !is_dec && !rst;
        dec_start = state == LAUNCH && is_dec && !rst;
        acc = stream.in_valid && stream.in_ready;
        legal = stream.in_data == CMD_ENC || stream.in_data == CMD_DEC;
        lim = state == KEY ? CW'(KB - 1) : state == AD ? CW'(AB - 1) : state == TEXT ? CW'(TB - 1) : CW'(15);
        last = acc && cnt == lim;
        // only a fresh 0->1 edge of the selected ready counts
        fire = is_dec ? dec_ready && !dec_prev : en_ready && !en_prev;
        nxt = state;
        case (state)
            IDLE:    nxt = acc && legal ? KEY : IDLE;
            KEY:     nxt = last ? NONCE : KEY;
            NONCE:   nxt = last ? AD : NONCE;
            AD:      nxt = last ? TEXT : AD;
            TEXT:    nxt = last ? (is_dec ? TAG : LAUNCH) : TEXT;
            TAG:     nxt = last ? LAUNCH : TAG;
            LAUNCH:  nxt = WAIT;
            default: nxt = fire ? IDLE : WAIT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            is_dec <= 1'b0;
            en_prev <= 1'b0;
            dec_prev <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            key <= '0;
            nonce <= '0;
            associated <= '0;
            text <= '0;
            tag_in <= '0;
        end else begin
            state <= nxt;
            cnt <= nxt != state ? '0 : cnt + CW'(acc);
            en_prev <= en_ready;
            dec_prev <= dec_ready;
            done <= state == WAIT && fire;
            err <= state == IDLE && acc && !legal;
            // each field is cleared as its state is entered, then shifted MSB-first
            if (acc) begin
                case (state)
                    IDLE: if (legal) begin
                        is_dec <= stream.in_data == CMD_DEC;
                        key <= '0;
                    end
                    KEY: begin
                        key <= KEY_l'({key, stream.in_data});
                        if (last) nonce <= '0;
                    end
                    NONCE: begin
                        nonce <= NT_W'({nonce, stream.in_data});
                        if (last) associated <= '0;
                    end
                    AD: begin
                        associated <= A_l'({associated, stream.in_data});
                        if (last) text <= '0;
                    end
                    TEXT: begin
                        text <= text_l'({text, stream.in_data});
                        if (last && is_dec) tag_in <= '0;
                    end
                    TAG: tag_in <= NT_W'({tag_in, stream.in_data});
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aead_loader.sv
// tb_aead_loader: randomized scoreboard bench for aead_loader with default widths.
module tb_aead_loader;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit dec;
        logic [127:0] key, nonce, tag;
        logic [39:0] ad, txt;
    } exp_t;

    logic clk = 0, rst = 1, en_ready = 0, dec_ready = 0;
    logic [127:0] key, nonce, tag_in;
    logic [39:0] associated, text;
    logic en_start, dec_start, busy, done, err;
    aead_loader_if bus();

    aead_loader dut (
        .clk(clk), .rst(rst), .stream(bus), .key(key), .nonce(nonce),
        .associated(associated), .text(text), .tag_in(tag_in),
        .en_start(en_start), .dec_start(dec_start), .en_ready(en_ready),
        .dec_ready(dec_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0, exp_done = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [127:0] m_key = '0, m_nonce = '0, m_tag = '0;
    logic [39:0] m_ad = '0, m_txt = '0;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chkb(input string n, input logic a, input logic e);
        chk(n, 128'(a), 128'(e));
    endtask

    task automatic chki(input string n, input int a, input int e);
        chk(n, 128'(a), 128'(e));
    endtask

    function automatic logic [127:0] pack(input bq_t q);
        logic [127:0] v = '0;
        foreach (q[i]) v = {v[119:0], q[i]};
        return v;
    endfunction

    function automatic void app(inout bq_t d, input bq_t s);
        foreach (s[i]) d.push_back(s[i]);
    endfunction

    // Monitor: every launch pulse must match the oldest issued frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (en_start || dec_start) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got en=%b dec=%b expected no start", en_start, dec_start);
                end else begin
                    mon_e = sb.pop_front();
                    chki("start_kind", int'({en_start, dec_start}), mon_e.dec ? 1 : 2);
                    chk("key", key, mon_e.key);
                    chk("nonce", nonce, mon_e.nonce);
                    chk("associated", 128'(associated), 128'(mon_e.ad));
                    chk("text", 128'(text), 128'(mon_e.txt));
                    chk("tag_in", tag_in, mon_e.tag);
                end
            end
            if (done) begin
                done_cnt++;
                chkb("busy_at_done", busy, 1'b0);
            end
            if (err) err_cnt++;
        end
    end

    task automatic chk_reset();
        chk("rst_key", key, '0);
        chk("rst_nonce", nonce, '0);
        chk("rst_ad", 128'(associated), '0);
        chk("rst_text", 128'(text), '0);
        chk("rst_tag", tag_in, '0);
        chki("rst_pulses", int'({en_start, dec_start, done, err}), 0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_in_ready", bus.in_ready, 1'b1);
        m_key = '0; m_nonce = '0; m_tag = '0; m_ad = '0; m_txt = '0;
    endtask

    // Sends a frame (or its first nbytes); called and returns at #1 after a clock edge.
    task automatic send(input logic [7:0] cmd, input int nbytes, input bit rnd,
                        input bit gaps, input bit push);
        bq_t kq, nq, aq, tq, gq, fr;
        bit dec = cmd == 8'h02;
        bit legal = cmd == 8'h01 || cmd == 8'h02;
        bit ok;
        int tries;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            kq.push_back(rnd ? 8'($urandom) : 8'(i));
            nq.push_back(rnd ? 8'($urandom) : 8'(8'h10 + i));
            gq.push_back(rnd ? 8'($urandom) : 8'(8'hA0 + i));
        end
        for (int i = 0; i < 5; i++) begin
            aq.push_back(rnd ? 8'($urandom) : 8'(8'h20 + i));
            tq.push_back(rnd ? 8'($urandom) : 8'(8'h30 + i));
        end
        fr.push_back(cmd);
        if (legal) begin
            app(fr, kq); app(fr, nq); app(fr, aq); app(fr, tq);
            if (dec) app(fr, gq);
        end
        if (nbytes < 0 || nbytes > fr.size()) nbytes = fr.size();
        if (legal && nbytes == fr.size()) begin
            m_key = pack(kq); m_nonce = pack(nq); m_ad = 40'(pack(aq)); m_txt = 40'(pack(tq));
            if (dec) m_tag = pack(gq);
            e.dec = dec; e.key = m_key; e.nonce = m_nonce; e.ad = m_ad; e.txt = m_txt; e.tag = m_tag;
            if (push) sb.push_back(e);
        end
        for (int i = 0; i < nbytes; i++) begin
            tries = 0;
            do begin
                bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.in_data = bus.in_valid ? fr[i] : 8'($urandom);
                ok = bus.in_valid && bus.in_ready;
                @(posedge clk);
                #1;
                if (++tries > 500) begin
                    bus.in_valid = 0;
                    checks++;
                    errors++;
                    $display("FAIL byte_accept: got no acceptance of byte %0d expected acceptance", i);
                    return;
                end
            end while (!ok);
        end
        bus.in_valid = 0;
        if (legal && push && nbytes == fr.size()) begin
            chki("launch_now", int'({en_start, dec_start}), dec ? 1 : 2);
            @(posedge clk);
            #1;
            chki("launch_one_cycle", int'({en_start, dec_start}), 0);
            chkb("busy_in_wait", busy, 1'b1);
            chkb("in_ready_in_wait", bus.in_ready, 1'b0);
        end
    endtask

    task automatic complete(input bit dec, input int hold, input bit drop);
        int d0 = done_cnt;
        repeat (hold) @(posedge clk);
        #1;
        chki("no_early_done", done_cnt, d0);
        chkb("busy_before_done", busy, 1'b1);
        if (dec) dec_ready = 1; else en_ready = 1;
        @(posedge clk);
        #1;
        chkb("done_pulse", done, 1'b1);
        chkb("idle_at_done", busy, 1'b0);
        exp_done++;
        if (drop) begin
            if (dec) dec_ready = 0; else en_ready = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit d;
        int d0;
        bus.in_valid = 0;
        bus.in_data = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk_reset();

        // encrypt pattern frame, full rate; en_ready left high afterwards
        send(8'h01, -1, 0, 0, 1);
        chk("enc_key_pattern", key, 128'h000102030405060708090A0B0C0D0E0F);
        chk("enc_ad_pattern", 128'(associated), 128'h2021222324);
        chk("enc_text_pattern", 128'(text), 128'h3031323334);
        complete(0, 3, 0);

        // back-to-back frame with stale en_ready
        chkb("ready_in_done_cycle", bus.in_ready, 1'b1);
        send(8'h01, -1, 1, 0, 1);
        d0 = done_cnt;
        repeat (5) @(posedge clk);
        #1;
        chki("stale_ready_no_done", done_cnt, d0);
        en_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chki("low_ready_no_done", done_cnt, d0);
        complete(0, 0, 1);

        // decrypt pattern frame while en_ready is held high
        en_ready = 1;
        send(8'h02, -1, 0, 0, 1);
        chk("dec_tag_pattern", tag_in, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        complete(1, 4, 1);
        en_ready = 0;

        // illegal command byte
        send(8'h07, -1, 0, 0, 0);
        chkb("err_pulse", err, 1'b1);
        chkb("err_idle", busy, 1'b0);
        @(posedge clk);
        #1;
        chkb("err_one_cycle", err, 1'b0);
        chk("err_key_kept", key, m_key);
        chk("err_text_kept", 128'(text), 128'(m_txt));
        chk("err_tag_kept", tag_in, m_tag);
        send(8'h01, -1, 1, 0, 1);
        complete(0, 1, 1);

        // gapped decrypt frame must assemble the same pattern
        send(8'h02, -1, 0, 1, 1);
        complete(1, 2, 1);

        // reset mid-NONCE
        send(8'h02, 1 + 16 + 5, 1, 0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk_reset();

        // reset in LAUNCH: the start pulse must not appear
        send(8'h01, -1, 1, 0, 0);
        rst = 1;
        #1;
        chki("launch_suppressed", int'({en_start, dec_start}), 0);
        @(posedge clk);
        #1;
        rst = 0;
        chk_reset();
        send(8'h02, -1, 1, 0, 1);
        complete(1, 0, 1);

        for (int i = 0; i < 4; i++) begin
            d = 1'($urandom_range(0, 1));
            send(d ? 8'h02 : 8'h01, -1, 1, 1, 1);
            complete(d, $urandom_range(0, 3), 1);
        end

        repeat (3) @(posedge clk);
        #1;
        chki("sb_empty", sb.size(), 0);
        chki("done_count", done_cnt, exp_done);
        chki("err_count", err_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aead_loader.md
# aead_loader

Byte-serial front end for the AEAD processing unit. Accepts a framed byte stream (command, key, nonce, associated data, text, optional tag) on a valid/ready interface, assembles the wide parallel fields the processing unit consumes, issues a one-cycle `en_start` or `dec_start`, and holds the fields stable until the matching `en_ready`/`dec_ready` rising edge completes the operation.

## Interface

Parameters:
- `KEY_l`, default 128: key width in bits; multiple of 8.
- `A_l`, default 40: associated-data width in bits; multiple of 8.
- `text_l`, default 40: plaintext/ciphertext width in bits; multiple of 8.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle; transfer when `in_valid & in_ready`.
- `key`  out  KEY_l  assembled key.
- `nonce`  out  128  assembled nonce.
- `associated`  out  A_l  assembled associated data.
- `text`  out  text_l  assembled plaintext (encrypt) or ciphertext (decrypt).
- `tag_in`  out  128  assembled expected tag; decrypt frames only, otherwise unchanged.
- `en_start`  out  1  one-cycle encrypt launch.
- `dec_start`  out  1  one-cycle decrypt launch.
- `en_ready`  in  1  encrypt complete, level.
- `dec_ready`  in  1  decrypt complete, level.
- `busy`  out  1  frame in progress or operation outstanding.
- `done`  out  1  one-cycle pulse on operation completion.
- `err`  out  1  one-cycle pulse on an illegal command byte.

## Operation

- Frame layout, each field MSB-first: command byte; `KEY_l/8` key bytes; 16 nonce bytes; `A_l/8` AD bytes; `text_l/8` text bytes; for decrypt, 16 tag bytes.
- Command byte: 0x01 = encrypt, 0x02 = decrypt. Any other value is consumed, pulses `err` the following cycle, and leaves the FSM in IDLE. Fields are untouched.
- Field assembly: on each accepted byte, `field <= {field[W-9:0], in_data}`. The target field is cleared to 0 on entry to its state, so a completed field contains exactly the frame bytes.
- FSM states: IDLE, KEY, NONCE, AD, TEXT, TAG, LAUNCH, WAIT.
  - IDLE → KEY on a legal command.
  - KEY → NONCE → AD → TEXT, each after its byte count is reached.
  - TEXT → TAG (decrypt) or → LAUNCH (encrypt).
  - TAG → LAUNCH.
  - LAUNCH → WAIT after one cycle.
  - WAIT → IDLE on the completion edge.
- Byte counter: width `$clog2(max(KEY_l/8, 16, A_l/8, text_l/8)) + 1`. Reset to 0 on each state entry. The state advances on the acceptance of byte `N-1`.
- LAUNCH: asserts exactly one of `en_start`/`dec_start` for one cycle, according to the latched command.
- WAIT completion: the first cycle where the selected ready input is 1 and was 0 in the previous cycle (registered previous value). The level ready left over from a prior operation does not complete a new one. The unselected ready input is ignored.
- `done` pulses in the cycle after completion is detected; the FSM is in IDLE in that same cycle.
- All field outputs hold their values in WAIT and after return to IDLE, until overwritten by the next frame.
- `busy` = (state != IDLE).

## Timing

- Reset values: state IDLE; all fields 0; `en_start`, `dec_start`, `done`, `err` = 0; `busy` = 0; `in_ready` = 1; ready-history registers 0.
- `in_ready` = 1 in IDLE, KEY, NONCE, AD, TEXT, TAG; 0 in LAUNCH and WAIT.
- Stalls: `in_valid` low in any loading state holds the state and counter. No timeout applies.
- Minimum frame-to-start latency: an encrypt frame of 43 bytes (default parameters) at full rate puts `en_start` high in the cycle after the last byte is accepted. A decrypt frame is 59 bytes.
- A new command byte is accepted in the cycle `done` pulses; back-to-back frames need no gap.
- `rst` in any state returns every register to its reset value the next cycle. A start pulse due in that cycle is suppressed.

## Structure

- Shared package `aead_pkg`:
  - command constants `CMD_ENC = 8'h01`, `CMD_DEC = 8'h02`;
  - FSM state enum;
  - nonce/tag width constant 128.
- Single module; no sub-module needed. Shift-register field capture stays inline.

## Test plan

- Encrypt frame at full rate: 0x01, key 00..0F, nonce 10..1F, AD 20..24, text 30..34. Expect `key = 0x000102…0F`, `associated = 0x2021222324`, `text = 0x3031323334`, `en_start` high for exactly one cycle one cycle after byte 43. Then `en_ready` 0→1 yields a `done` pulse and `busy` = 0.
- Decrypt frame with tag bytes A0..AF: expect `tag_in = 0xA0A1…AF`, `dec_start` only, `en_start` never high. Completion occurs only on a `dec_ready` rising edge; holding `en_ready` = 1 throughout has no effect.
- Illegal command 0x07: `err` pulses once, FSM stays in IDLE, fields are unchanged. A following valid frame then completes normally.
- Random `in_valid` gaps (about 50% duty) across a full frame: field values are identical to the full-rate case, with no dropped or duplicated bytes.
- Stale ready: hold `en_ready` = 1 from a prior operation into a new encrypt. No `done` until `en_ready` drops and rises again.
- `rst` asserted mid-NONCE and again in LAUNCH: all outputs return to their reset values the next cycle, no start pulse is emitted, and the next frame loads correctly.
